// File: rtl/rc4_pkg.sv
// rc4_pkg: types and constants shared by the RC4 KSA swap engine and the later PRGA/decrypt block.
//   byte_t      - one S-box entry / key byte
//   S_SIZE      - number of S-box entries
//   ksa_state_t - controller state encoding
package rc4_pkg;
    typedef logic [7:0] byte_t;
    localparam int S_SIZE = 256;
    typedef enum logic [2:0] {IDLE, RD_I, CALC, RD_J, WR_I, WR_J, DONE} ksa_state_t;
endpackage

// File: rtl/key_schedule_swap.sv
// key_schedule_swap: RC4 key-scheduling swap engine over a single-port s_memory.
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   start   - one-cycle run request, sampled in IDLE/DONE only
//   key     - secret key, byte 0 in the top 8 bits
//   address - s_memory address (registered)
//   data    - s_memory write data (registered)
//   wren    - s_memory write enable (registered)
//   q       - s_memory read data
//   busy    - this block owns the s_memory port
//   done    - level, set after the last swap until the next accepted start
module key_schedule_swap
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int RD_WAIT   = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    output byte_t                  address,
    output byte_t                  data,
    output logic                   wren,
    input  byte_t                  q,
    output logic                   busy,
    output logic                   done
);
    localparam int CW = $clog2(RD_WAIT + 1);
    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    ksa_state_t    state_q;
    byte_t         i_q, j_q, si_q, addr_q, data_q;
    byte_t         key_byte, j_d;
    logic [KW-1:0] k_q;
    logic [CW-1:0] wait_q;
    logic          wren_q, busy_q, done_q;
    logic          rd_last;

    assign key_byte = key[8*(KEY_BYTES-1-int'(k_q)) +: 8];
    assign j_d      = j_q + si_q + key_byte;
    assign rd_last  = wait_q == CW'(RD_WAIT - 1);

    assign address = addr_q;
    assign data    = data_q;
    assign wren    = wren_q;
    assign busy    = busy_q;
    assign done    = done_q;

    // data_q also serves as the S[j] latch: it is loaded from q at the end of RD_J
    // and presented unchanged during WR_I.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            wait_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: if (start) begin
                    state_q <= RD_I;
                    i_q     <= '0;
                    j_q     <= '0;
                    k_q     <= '0;
                    wait_q  <= '0;
                    addr_q  <= '0;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                end
                RD_I: begin
                    wait_q <= rd_last ? '0 : wait_q + 1'b1;
                    if (rd_last) begin
                        si_q    <= q;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    j_q     <= j_d;
                    addr_q  <= j_d;
                    state_q <= RD_J;
                end
                RD_J: begin
                    wait_q <= rd_last ? '0 : wait_q + 1'b1;
                    if (rd_last) begin
                        addr_q  <= i_q;
                        data_q  <= q;
                        wren_q  <= 1'b1;
                        state_q <= WR_I;
                    end
                end
                WR_I: begin
                    addr_q  <= j_q;
                    data_q  <= si_q;
                    state_q <= WR_J;
                end
                WR_J: begin
                    wren_q <= 1'b0;
                    if (i_q == byte_t'(S_SIZE - 1)) begin
                        state_q <= DONE;
                        addr_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        i_q     <= i_q + 8'd1;
                        addr_q  <= i_q + 8'd1;
                        k_q     <= (k_q == KW'(KEY_BYTES - 1)) ? '0 : k_q + 1'b1;
                        state_q <= RD_I;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_schedule_swap.sv
// tb_key_schedule_swap: directed bench for key_schedule_swap with a registered-address
// 256x8 memory model and a golden RC4 KSA model.
module tb_key_schedule_swap;
    import rc4_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        init_req = 1'b0;
    logic [23:0] key = '0;
    byte_t       address, data, q;
    logic        wren, busy, done;

    byte_t       mem [256];
    byte_t       gold [256];
    byte_t       addr_r = '0;
    logic [15:0] wlog [4096];
    int          wr_total = 0;
    int          checks = 0;
    int          errors = 0;

    always #10 clk = ~clk;

    key_schedule_swap #(.KEY_BYTES(3), .RD_WAIT(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .key(key),
        .address(address), .data(data), .wren(wren), .q(q),
        .busy(busy), .done(done)
    );

    always @(posedge clk) begin
        addr_r <= address;
        if (init_req) for (int a = 0; a < 256; a++) mem[a] <= byte_t'(a);
        else if (wren) mem[address] <= data;
    end
    assign q = mem[addr_r];

    always @(negedge clk) if (wren) begin
        if (wr_total < 4096) wlog[wr_total] = {address, data};
        wr_total++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic golden(input logic [23:0] k);
        byte_t j, t, kb;
        j = '0;
        for (int a = 0; a < 256; a++) gold[a] = byte_t'(a);
        for (int a = 0; a < 256; a++) begin
            kb = k[23 - 8*(a % 3) -: 8];
            j = j + gold[a] + kb;
            t = gold[a];
            gold[a] = gold[j];
            gold[j] = t;
        end
    endtask

    task automatic compare_mem(input string tag);
        int bad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== gold[a]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic reinit();
        @(negedge clk) init_req = 1'b1;
        @(negedge clk) init_req = 1'b0;
    endtask

    task automatic run(input logic [23:0] k, input int pulse_at, output int lat, output int nwr, output int base);
        int n = 0;
        key = k;
        @(negedge clk);
        start = 1'b1;
        base = wr_total;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_rise", busy, 1);
        check("done_drop", done, 0);
        while (!done && n < 5000) begin
            @(posedge clk);
            #1 n++;
            start = (n == pulse_at);
        end
        start = 1'b0;
        lat = n + 1;
        nwr = wr_total - base;
        check("done_seen", done, 1);
    endtask

    initial begin
        int lat, nwr, base;
        #1;
        check("rst_address", address, 0);
        check("rst_data", data, 0);
        check("rst_wren", wren, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk) reset_n = 1'b1;

        reinit();
        golden(24'h010203);
        run(24'h010203, 0, lat, nwr, base);
        check("t1_wr0", wlog[base],   16'h0001);
        check("t1_wr1", wlog[base+1], 16'h0100);
        check("t1_wr2", wlog[base+2], 16'h0103);
        check("t1_wr3", wlog[base+3], 16'h0300);
        compare_mem("t1_array");

        reinit();
        golden(24'h000000);
        run(24'h000000, 0, lat, nwr, base);
        check("t2_wr0", wlog[base],   16'h0000);
        check("t2_wr1", wlog[base+1], 16'h0000);
        compare_mem("t2_array");

        reinit();
        golden(24'h000249);
        run(24'h000249, 0, lat, nwr, base);
        check("t3_latency", lat, 1793);
        check("t3_wren_cycles", nwr, 512);
        compare_mem("t3_array");

        reinit();
        run(24'h000249, 100, lat, nwr, base);
        check("t4_latency", lat, 1793);
        check("t4_wren_cycles", nwr, 512);
        compare_mem("t4_array");

        reinit();
        key = 24'h000249;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10*7 + 3) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("t5_address", address, 0);
        check("t5_data", data, 0);
        check("t5_wren", wren, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        @(negedge clk) reset_n = 1'b1;
        reinit();
        run(24'h000249, 0, lat, nwr, base);
        check("t5_latency", lat, 1793);
        compare_mem("t5_array");

        reinit();
        run(24'h000249, 0, lat, nwr, base);
        check("t6_latency", lat, 1793);
        check("t6_wren_cycles", nwr, 512);
        compare_mem("t6_array");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
